// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI access controller.
package hpi_pkg;

  typedef enum logic [2:0] {
    StRst,
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StDone
  } hpi_state_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // Phase timer width; all cycle parameters must fit.
  localparam int unsigned TimerW = 16;

endpackage

// File: rtl/hpi_phase_timer.sv
// Loadable down-counter with zero flag; one instance paces every timed FSM state.
module hpi_phase_timer #(
  parameter int unsigned      Width    = 16,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] count_o,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= ResetVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/hpi_access_ctrl.sv
// Sequences single HPI register accesses (setup/strobe/hold) and the chip reset pulse.
module hpi_access_ctrl
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned RST_CYC    = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  input  logic        chip_rst_req,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic        hpi_cs_n,
  output logic        hpi_reset_n
);

  localparam logic [TimerW-1:0] LdSetup  = TimerW'(SETUP_CYC - 1);
  localparam logic [TimerW-1:0] LdStrobe = TimerW'(STROBE_CYC - 1);
  localparam logic [TimerW-1:0] LdHold   = TimerW'(HOLD_CYC - 1);
  localparam logic [TimerW-1:0] LdRst    = TimerW'(RST_CYC - 1);
  // Timer value during the second HOLD cycle, when registered read data is valid.
  localparam logic [TimerW-1:0] RdSample = TimerW'(HOLD_CYC - 2);

  hpi_state_e state_q, state_d;
  logic        pend_q, pend_d;
  logic        write_q;
  logic [1:0]  addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q, rdata_d;
  logic        rsp_valid_q;
  logic        cs_n_q, r_n_q, w_n_q, reset_n_q;

  logic              tmr_load;
  logic [TimerW-1:0] tmr_val;
  logic [TimerW-1:0] tmr_cnt;
  logic              tmr_zero;
  logic              accept;

  assign req_ready = (state_q == StIdle) && !chip_rst_req;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != StIdle);

  hpi_phase_timer #(
    .Width   (TimerW),
    .ResetVal(LdRst)
  ) u_timer (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .count_o   (tmr_cnt),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    rdata_d  = rdata_q;
    tmr_load = 1'b0;
    tmr_val  = LdRst;
    unique case (state_q)
      StRst: begin
        if (tmr_zero) state_d = StIdle;
      end
      StIdle: begin
        if (chip_rst_req) begin
          state_d  = StRst;
          tmr_load = 1'b1;
          tmr_val  = LdRst;
        end else if (accept) begin
          state_d  = StSetup;
          tmr_load = 1'b1;
          tmr_val  = LdSetup;
        end
      end
      StSetup: begin
        if (tmr_zero) begin
          state_d  = StStrobe;
          tmr_load = 1'b1;
          tmr_val  = LdStrobe;
        end
      end
      StStrobe: begin
        if (tmr_zero) begin
          state_d  = StHold;
          tmr_load = 1'b1;
          tmr_val  = LdHold;
        end
      end
      StHold: begin
        if (!write_q && (tmr_cnt == RdSample)) rdata_d = hpi_data_in;
        if (tmr_zero) state_d = StDone;
      end
      StDone: begin
        if (pend_q || chip_rst_req) begin
          state_d  = StRst;
          tmr_load = 1'b1;
          tmr_val  = LdRst;
          pend_d   = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StRst;
    endcase
    // A chip reset requested mid-access waits until the access finishes.
    if (chip_rst_req && (state_q inside {StSetup, StStrobe, StHold})) pend_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StRst;
      pend_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      cs_n_q      <= 1'b1;
      r_n_q       <= 1'b1;
      w_n_q       <= 1'b1;
      reset_n_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // Pin-facing strobes are decoded from the next state so they leave flops directly.
      rsp_valid_q <= (state_d == StDone);
      cs_n_q      <= !(state_d inside {StSetup, StStrobe, StHold});
      r_n_q       <= !((state_d == StStrobe) && !write_q);
      w_n_q       <= !((state_d == StStrobe) && write_q);
      reset_n_q   <= (state_d != StRst);
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign hpi_address  = addr_q;
  assign hpi_data_out = wdata_q;
  assign hpi_cs_n     = cs_n_q;
  assign hpi_r_n      = r_n_q;
  assign hpi_w_n      = w_n_q;
  assign hpi_reset_n  = reset_n_q;

endmodule

// File: tb/tb_hpi_access_ctrl.sv
// Directed bench for hpi_access_ctrl with a registered pin model on the read path.
module tb_hpi_access_ctrl;
  import hpi_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_addr;
  logic [15:0] req_wdata;
  logic        chip_rst_req;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [1:0]  hpi_address;
  logic [15:0] hpi_data_out;
  logic [15:0] hpi_data_in;
  logic        hpi_r_n, hpi_w_n, hpi_cs_n, hpi_reset_n;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  hpi_access_ctrl dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .chip_rst_req(chip_rst_req),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .hpi_address (hpi_address),
    .hpi_data_out(hpi_data_out),
    .hpi_data_in (hpi_data_in),
    .hpi_r_n     (hpi_r_n),
    .hpi_w_n     (hpi_w_n),
    .hpi_cs_n    (hpi_cs_n),
    .hpi_reset_n (hpi_reset_n)
  );

  // Pin model: io strobe register, device drives while its strobe is low, io data register.
  logic        pin_r_n = 1'b1;
  logic [15:0] pin_val = 16'hBEEF;
  always @(posedge Clk) begin
    pin_r_n     <= hpi_r_n;
    hpi_data_in <= (!pin_r_n) ? pin_val : 16'h0000;
  end

  // Runs one access; bit k of each mask is sampled in cycle k after acceptance (cycle 0).
  task automatic run_access(input logic w, input logic [1:0] a, input logic [15:0] d,
                            input bit hold, input int crst_at, input int nrst_at,
                            input int ncyc,
                            output logic [31:0] cs_m, output logic [31:0] w_m,
                            output logic [31:0] r_m, output logic [31:0] rv_m,
                            output logic [31:0] acc_m, output logic [31:0] rn_m,
                            output logic [15:0] rd, output bit bad, output bit to);
    int n;
    cs_m = '0; w_m = '0; r_m = '0; rv_m = '0; acc_m = '0; rn_m = '0;
    rd = '0; bad = 1'b0; to = 1'b0;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    @(negedge Clk);
    while (!req_ready && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!req_ready) begin
      to = 1'b1;
      req_valid = 1'b0;
      return;
    end
    @(posedge Clk);
    #1;
    req_valid = hold;
    acc_m[0] = 1'b1;
    for (int k = 1; k < ncyc; k++) begin
      chip_rst_req = (k == crst_at);
      if (k == nrst_at) Reset_n = 1'b0;
      @(negedge Clk);
      cs_m[k]  = !hpi_cs_n;
      w_m[k]   = !hpi_w_n;
      r_m[k]   = !hpi_r_n;
      rv_m[k]  = rsp_valid;
      acc_m[k] = req_valid && req_ready;
      rn_m[k]  = !hpi_reset_n;
      if (rsp_valid) rd = rsp_rdata;
      if ((!hpi_r_n && !hpi_w_n) || ((!hpi_r_n || !hpi_w_n) && hpi_cs_n)) bad = 1'b1;
      @(posedge Clk);
      #1;
    end
    chip_rst_req = 1'b0;
    req_valid = 1'b0;
  endtask

  // Counts consecutive sampled cycles with hpi_reset_n low, starting with the current cycle.
  task automatic count_rst_low(output int n, output bit saw_cs, output bit saw_rv);
    n = 0; saw_cs = 1'b0; saw_rv = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (!hpi_cs_n) saw_cs = 1'b1;
      if (rsp_valid) saw_rv = 1'b1;
      if (hpi_reset_n) break;
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    bit sc, sr;
    Reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; chip_rst_req = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (hpi_reset_n !== 1'b0) begin errors++;
      $display("FAIL reset_hpi_reset_n: got %b expected 0", hpi_reset_n); end
    checks++;
    if ({hpi_cs_n, hpi_r_n, hpi_w_n} !== 3'b111) begin errors++;
      $display("FAIL reset_strobes: got %b expected 111", {hpi_cs_n, hpi_r_n, hpi_w_n}); end
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++;
      $display("FAIL reset_busy_ready: got %b%b expected 10", busy, req_ready); end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0) begin errors++;
      $display("FAIL reset_rsp: got %b/%h expected 0/0000", rsp_valid, rsp_rdata); end
    checks++;
    if (hpi_address !== 2'd0 || hpi_data_out !== 16'h0) begin errors++;
      $display("FAIL reset_addr_data: got %h/%h expected 0/0000", hpi_address, hpi_data_out); end
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    count_rst_low(n, sc, sr);
    checks++;
    if (n != 16) begin errors++;
      $display("FAIL reset_len: got %0d expected 16", n); end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_then_ready: got ready=%b busy=%b expected 1/0", req_ready, busy); end
  endtask

  task automatic test_write(input logic [15:0] data, input logic [15:0] exp_rd, input string tag);
    logic [31:0] cs_m, w_m, r_m, rv_m, acc_m, rn_m;
    logic [15:0] rd;
    bit bad, to;
    run_access(1'b1, HPI_ADDR, data, 1'b0, -1, -1, 12,
               cs_m, w_m, r_m, rv_m, acc_m, rn_m, rd, bad, to);
    checks++;
    if (to) begin errors++; $display("FAIL %s_accept: got timeout expected accept", tag); end
    checks++;
    if (cs_m !== 32'h1FE) begin errors++;
      $display("FAIL %s_cs: got %h expected 000001fe", tag, cs_m); end
    checks++;
    if (w_m !== 32'h78 || r_m !== 32'h0) begin errors++;
      $display("FAIL %s_strobe: got w=%h r=%h expected w=00000078 r=0", tag, w_m, r_m); end
    checks++;
    if (rv_m !== 32'h200) begin errors++;
      $display("FAIL %s_rsp_valid: got %h expected 00000200", tag, rv_m); end
    checks++;
    if (rd !== exp_rd) begin errors++;
      $display("FAIL %s_rdata_kept: got %h expected %h", tag, rd, exp_rd); end
    checks++;
    if (hpi_address !== HPI_ADDR || hpi_data_out !== data) begin errors++;
      $display("FAIL %s_addr_data: got %h/%h expected 2/%h", tag, hpi_address, hpi_data_out,
               data); end
  endtask

  task automatic test_read();
    logic [31:0] cs_m, w_m, r_m, rv_m, acc_m, rn_m;
    logic [15:0] rd;
    bit bad, to;
    run_access(1'b0, HPI_DATA, 16'h5555, 1'b0, -1, -1, 12,
               cs_m, w_m, r_m, rv_m, acc_m, rn_m, rd, bad, to);
    checks++;
    if (to || rv_m !== 32'h200) begin errors++;
      $display("FAIL read_rsp_valid: got %h expected 00000200", rv_m); end
    checks++;
    if (rd !== 16'hBEEF) begin errors++;
      $display("FAIL read_rdata: got %h expected beef", rd); end
    checks++;
    if (r_m !== 32'h78 || w_m !== 32'h0 || bad) begin errors++;
      $display("FAIL read_strobe: got r=%h w=%h bad=%b expected r=00000078 w=0 bad=0",
               r_m, w_m, bad); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cs_m, w_m, r_m, rv_m, acc_m, rn_m;
    logic [15:0] rd;
    bit bad, to;
    run_access(1'b0, HPI_STATUS, 16'h0, 1'b1, -1, -1, 20,
               cs_m, w_m, r_m, rv_m, acc_m, rn_m, rd, bad, to);
    checks++;
    if (to || acc_m !== 32'h401) begin errors++;
      $display("FAIL b2b_accept: got %h expected 00000401", acc_m); end
    checks++;
    if (rv_m !== 32'h80200) begin errors++;
      $display("FAIL b2b_rsp_valid: got %h expected 00080200", rv_m); end
    checks++;
    if (cs_m !== 32'h7F9FE) begin errors++;
      $display("FAIL b2b_cs: got %h expected 0007f9fe", cs_m); end
    checks++;
    if (r_m !== 32'h1E078 || bad) begin errors++;
      $display("FAIL b2b_strobe: got %h bad=%b expected 0001e078 bad=0", r_m, bad); end
  endtask

  task automatic test_chip_rst_in_access();
    logic [31:0] cs_m, w_m, r_m, rv_m, acc_m, rn_m;
    logic [15:0] rd;
    bit bad, to, sc, sr;
    int n;
    run_access(1'b1, HPI_MAILBOX, 16'hA5A5, 1'b0, 4, -1, 11,
               cs_m, w_m, r_m, rv_m, acc_m, rn_m, rd, bad, to);
    checks++;
    if (to || rv_m !== 32'h200) begin errors++;
      $display("FAIL crst_access_rsp: got %h expected 00000200", rv_m); end
    checks++;
    if (rn_m !== 32'h400) begin errors++;
      $display("FAIL crst_start: got %h expected 00000400", rn_m); end
    count_rst_low(n, sc, sr);
    checks++;
    if (n + 1 != 16) begin errors++;
      $display("FAIL crst_len: got %0d expected 16", n + 1); end
    checks++;
    if (req_ready !== 1'b1) begin errors++;
      $display("FAIL crst_then_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_chip_rst_idle();
    int n;
    bit sc, sr;
    @(posedge Clk);
    #1;
    req_valid = 1'b1; req_write = 1'b0; chip_rst_req = 1'b1;
    @(negedge Clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++;
      $display("FAIL idle_crst_ready: got %b expected 0", req_ready); end
    @(posedge Clk);
    #1;
    req_valid = 1'b0; chip_rst_req = 1'b0;
    count_rst_low(n, sc, sr);
    checks++;
    if (n != 16) begin errors++;
      $display("FAIL idle_crst_len: got %0d expected 16", n); end
    checks++;
    if (sc || sr) begin errors++;
      $display("FAIL idle_crst_no_access: got cs=%b rv=%b expected 0/0", sc, sr); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] cs_m, w_m, r_m, rv_m, acc_m, rn_m;
    logic [15:0] rd;
    bit bad, to, sc, sr;
    int n;
    run_access(1'b1, HPI_STATUS, 16'h7777, 1'b0, -1, 1, 3,
               cs_m, w_m, r_m, rv_m, acc_m, rn_m, rd, bad, to);
    checks++;
    if (to || cs_m !== 32'h0) begin errors++;
      $display("FAIL nrst_cs: got %h expected 0", cs_m); end
    checks++;
    if (rsp_rdata !== 16'h0 || hpi_address !== 2'd0 || hpi_data_out !== 16'h0) begin errors++;
      $display("FAIL nrst_clear: got %h/%h/%h expected 0/0/0", rsp_rdata, hpi_address,
               hpi_data_out); end
    Reset_n = 1'b1;
    count_rst_low(n, sc, sr);
    checks++;
    if (n != 16) begin errors++;
      $display("FAIL nrst_len: got %0d expected 16", n); end
    checks++;
    if (rv_m !== 32'h0 || sr) begin errors++;
      $display("FAIL nrst_no_rsp: got %h/%b expected 0/0", rv_m, sr); end
  endtask

  initial begin
    test_reset();
    test_write(16'h1234, 16'h0000, "write1");
    test_read();
    test_write(16'h4321, 16'hBEEF, "write2");
    test_back_to_back();
    test_chip_rst_in_access();
    test_chip_rst_idle();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hpi_access_ctrl.md
HPI_ACCESS_CTRL -- requirements
Module: hpi_access_ctrl

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning:
  SETUP_CYC  2   cycles address/data/CS are held before strobe (>=1)
  STROBE_CYC 4   cycles RD/WR strobe is held low (>=2)
  HOLD_CYC   2   cycles address/data/CS are held after strobe (>=2)
  RST_CYC    16  cycles chip reset is held low after block reset or a chip_rst_req
REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning:
  Clk           in  1   single clock; all logic on rising edge
  Reset_n       in  1   asynchronous, active-low reset
  req_valid     in  1   access request
  req_ready     out 1   block accepts request this cycle
  req_write     in  1   1=write, 0=read
  req_addr      in  2   HPI register select
  req_wdata     in  16  write data
  chip_rst_req  in  1   pulse: re-run chip reset sequence
  rsp_valid     out 1   one-cycle pulse: access complete
  rsp_rdata     out 16  read data, valid with rsp_valid
  busy          out 1   high in any state except IDLE
  hpi_address   out 2   to io interface address input
  hpi_data_out  out 16  to io interface write data
  hpi_data_in   in  16  from io interface (one-cycle registered pin data)
  hpi_r_n, hpi_w_n, hpi_cs_n, hpi_reset_n  out 1 each  active-low strobes to io interface

Function
REQ-003 The FSM SHALL have states RST, IDLE, SETUP, STROBE, HOLD, DONE.
REQ-004 RST SHALL drive hpi_reset_n=0, cs_n/r_n/w_n=1, and exit to IDLE after exactly RST_CYC cycles.
REQ-005 In IDLE, req_ready SHALL be 1; a request is accepted when req_valid && req_ready, and write, address and wdata SHALL then be latched.
REQ-006 Acceptance SHALL move to SETUP: hpi_cs_n=0, hpi_address and hpi_data_out = latched values, strobes high, for SETUP_CYC cycles.
REQ-007 STROBE SHALL hold hpi_r_n=0 (read) or hpi_w_n=0 (write) for STROBE_CYC cycles, with cs_n=0 and address/data unchanged.
REQ-008 HOLD SHALL hold cs_n=0, strobes high, and address/data unchanged for HOLD_CYC cycles.
REQ-009 On a read, rsp_rdata SHALL capture hpi_data_in at the end of the second HOLD cycle; this accounts for the two-stage registered path, so it samples pin data from the last strobe-low cycle.
REQ-010 DONE SHALL last one cycle with rsp_valid=1 and cs_n=1, then return to IDLE.
REQ-011 On a write, rsp_rdata SHALL keep its previous value.
REQ-012 Access latency from acceptance to rsp_valid SHALL be exactly SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles; back-to-back throughput SHALL be one access per SETUP_CYC+STROBE_CYC+HOLD_CYC+2 cycles.
REQ-013 req_ready SHALL be 0 outside IDLE; req_valid outside IDLE SHALL be ignored and not queued.
REQ-014 chip_rst_req in IDLE SHALL enter RST.
REQ-015 chip_rst_req during an access SHALL be latched and take effect after DONE.
REQ-016 If chip_rst_req and req_valid are both high in IDLE, chip_rst_req SHALL win and req_ready SHALL be 0 that cycle.
REQ-017 hpi_r_n and hpi_w_n SHALL never be low simultaneously, and neither SHALL be low while hpi_cs_n=1.
REQ-018 All hpi_* outputs SHALL be driven directly from flops.

Reset
REQ-019 Assertion of Reset_n SHALL asynchronously force state RST, hpi_reset_n=0, hpi_cs_n/r_n/w_n=1, hpi_address=0, hpi_data_out=0, rsp_valid=0, rsp_rdata=0, req_ready=0, busy=1, and clear the pending chip-reset flag.
REQ-020 Reset_n asserted mid-access SHALL abort the access with no rsp_valid; the RST sequence SHALL restart from zero on release.

Structure
REQ-021 Package hpi_pkg SHALL hold the state enum and HPI address constants HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDR=2, HPI_STATUS=3.
REQ-022 One sub-module, hpi_phase_timer, SHALL be a loadable down-counter with a zero flag, shared by all timed states.

Verification
REQ-023 The bench SHALL cover these directed scenarios (default parameters):
  Reset release -> hpi_reset_n low exactly 16 cycles, then req_ready=1.
  Write addr=2, data=0x1234 -> cs_n low 8 cycles, w_n low cycles 3-6 after acceptance, rsp_valid at cycle 9.
  Read addr=0, with a pin model returning 0xBEEF via a one-cycle register -> rsp_rdata=0xBEEF with rsp_valid.
  req_valid held high for two accesses -> second acceptance exactly 10 cycles after the first; no overlap of strobes.
  chip_rst_req during STROBE -> access completes with rsp_valid, then 16-cycle hpi_reset_n low.
  Reset_n asserted during SETUP -> immediate cs_n=1, no rsp_valid, full RST sequence on release.
